// File: rtl/branch_predictor.sv
// Purpose : direct-mapped branch target buffer with 2-bit saturating direction
//           counters, plus a registered mispredict pulse and a wrapping
//           mispredict counter.
// Latency : prediction is combinational in the lookup cycle; table writes,
//           mispredict and mispredict_cnt take effect at the next rising edge.
// Backpressure: none; one lookup and one resolution accepted every cycle.
//
// Ports:
//   clk, rst           single clock, asynchronous active-high reset
//   pred_pc            fetch PC to predict
//   pred_taken         predicted direction for pred_pc
//   pred_target        stored target when predicted taken, else pred_pc + 4
//   upd_valid          resolution strobe from execute
//   upd_is_branch      resolved instruction is a conditional branch
//   upd_pc             PC of the resolved instruction
//   upd_taken          actual direction
//   upd_target         actual target
//   upd_pred_taken     direction predicted for this instruction at fetch
//   mispredict         one-cycle pulse after a mispredicted branch resolves
//   mispredict_cnt     number of mispredict pulses, wraps at 16 bits
module branch_predictor #(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES),
  localparam int TAG_W = 32 - IDX_W - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_is_branch,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  output logic        mispredict,
  output logic [15:0] mispredict_cnt
);

  // Counter encodings.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Table storage.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // ---------------------------------------------------------------------------
  // Lookup path (reads pre-update state; a same-cycle write lands next edge)
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] pred_idx;
  logic [TAG_W-1:0] pred_tag;
  logic             pred_hit;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign pred_tag = pred_pc[31:IDX_W+2];
  assign pred_hit = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);

  assign pred_taken  = pred_hit && ctr_q[pred_idx][1];
  assign pred_target = pred_taken ? target_q[pred_idx] : (pred_pc + 32'd4);

  // The byte offset within a word never participates in indexing or tagging.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pred_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_fire;
  logic             upd_hit;
  logic             upd_we;
  logic [1:0]       upd_ctr_cur;
  logic [1:0]       upd_ctr_nxt;

  assign upd_idx     = upd_pc[IDX_W+1:2];
  assign upd_tag     = upd_pc[31:IDX_W+2];
  assign upd_fire    = upd_valid && upd_is_branch;
  assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign upd_ctr_cur = ctr_q[upd_idx];

  // A not-taken miss leaves the entry alone so a cold not-taken branch does not
  // evict a useful taken entry that happens to share the index.
  assign upd_we = upd_fire && (upd_hit || upd_taken);

  always_comb begin
    upd_ctr_nxt = upd_ctr_cur;
    if (!upd_hit) begin
      // Fresh allocation starts weakly taken.
      upd_ctr_nxt = CTR_WT;
    end else if (upd_taken) begin
      if (upd_ctr_cur != CTR_ST) begin
        upd_ctr_nxt = upd_ctr_cur + 2'd1;
      end
    end else begin
      if (upd_ctr_cur != CTR_SNT) begin
        upd_ctr_nxt = upd_ctr_cur - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx] <= 1'b1;
      tag_q[upd_idx]   <= upd_tag;
      ctr_q[upd_idx]   <= upd_ctr_nxt;
      // Target only moves on a taken resolution; a not-taken hit keeps the
      // last known taken target for when the counter swings back.
      if (upd_taken) begin
        target_q[upd_idx] <= upd_target;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mispredict reporting
  // ---------------------------------------------------------------------------
  logic misp_now;
  assign misp_now = upd_fire && (upd_taken != upd_pred_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict     <= 1'b0;
      mispredict_cnt <= 16'h0000;
    end else begin
      mispredict <= misp_now;
      if (misp_now) begin
        mispredict_cnt <= mispredict_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENTRIES = 16;

  logic        clk;
  logic        rst;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic        upd_is_branch;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic        mispredict;
  logic [15:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_is_branch  (upd_is_branch),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .mispredict     (mispredict),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural model: per-slot record with an integer confidence 0..3,
  // slot = (pc / 4) mod ENTRIES, tag = pc / (4 * ENTRIES).
  // ---------------------------------------------------------------------------
  bit          m_valid  [ENTRIES];
  longint      m_tag    [ENTRIES];
  longint      m_target [ENTRIES];
  int          m_conf   [ENTRIES];
  bit          m_misp;
  int          m_cnt;

  function automatic int slot_of(input longint pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic longint tag_of(input longint pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit model_taken(input longint pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && (m_tag[s] == tag_of(pc)) && (m_conf[s] >= 2);
  endfunction

  function automatic longint model_target(input longint pc);
    if (model_taken(pc)) return m_target[slot_of(pc)];
    return (pc + 4) % 64'h1_0000_0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[i]  = 1'b0;
        m_tag[i]    = 0;
        m_target[i] = 0;
        m_conf[i]   = 1;
      end
      m_misp = 1'b0;
      m_cnt  = 0;
    end else begin
      m_misp = 1'b0;
      if (upd_valid && upd_is_branch) begin
        int     s;
        longint pc;
        pc = longint'(upd_pc);
        s  = slot_of(pc);
        if (m_valid[s] && m_tag[s] == tag_of(pc)) begin
          if (upd_taken) begin
            m_conf[s]   = (m_conf[s] < 3) ? m_conf[s] + 1 : 3;
            m_target[s] = longint'(upd_target);
          end else begin
            m_conf[s] = (m_conf[s] > 0) ? m_conf[s] - 1 : 0;
          end
        end else if (upd_taken) begin
          m_valid[s]  = 1'b1;
          m_tag[s]    = tag_of(pc);
          m_target[s] = longint'(upd_target);
          m_conf[s]   = 2;
        end
        if (upd_taken != upd_pred_taken) begin
          m_misp = 1'b1;
          m_cnt  = (m_cnt + 1) % 65536;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("model pred_taken", {31'd0, pred_taken}, {31'd0, model_taken(longint'(pred_pc))});
    chk("model pred_target", pred_target, 32'(model_target(longint'(pred_pc))));
    chk("model mispredict", {31'd0, mispredict}, {31'd0, m_misp});
    chk("model mispredict_cnt", {16'd0, mispredict_cnt}, 32'(m_cnt));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                           input logic ptaken, input logic isbr);
    upd_valid      = 1'b1;
    upd_is_branch  = isbr;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_pred_taken = ptaken;
  endtask

  task automatic do_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                        input logic ptaken, input logic isbr);
    drive_upd(pc, taken, tgt, ptaken, isbr);
    step();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_tgt);
    pred_pc = pc;
    #1;
    chk({name, " taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    chk({name, " target"}, pred_target, exp_tgt);
  endtask

  initial begin
    rst = 1'b1;
    pred_pc = 32'h0000_1000;
    upd_valid = 1'b0;
    upd_is_branch = 1'b0;
    upd_pc = '0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Cold lookup after reset.
    look("cold 0x1000", 32'h0000_1000, 1'b0, 32'h0000_1004);
    chk("reset mispredict", {31'd0, mispredict}, 32'd0);
    chk("reset cnt", {16'd0, mispredict_cnt}, 32'd0);

    // Same-cycle allocate + lookup on the same slot: old miss visible.
    drive_upd(32'h0000_1000, 1'b1, 32'h0000_0800, 1'b0, 1'b1);
    look("same-cycle 0x1000", 32'h0000_1000, 1'b0, 32'h0000_1004);
    step();
    upd_valid = 1'b0;
    chk("alloc mispredict", {31'd0, mispredict}, 32'd1);
    chk("alloc cnt", {16'd0, mispredict_cnt}, 32'd1);
    look("alloc 0x1000", 32'h0000_1000, 1'b1, 32'h0000_0800);
    step();
    chk("pulse one cycle", {31'd0, mispredict}, 32'd0);

    // Saturation then hysteresis.
    repeat (3) do_upd(32'h0000_1000, 1'b1, 32'h0000_0800, 1'b1, 1'b1);
    chk("sat no misp cnt", {16'd0, mispredict_cnt}, 32'd1);
    do_upd(32'h0000_1000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    look("hyst 1st nt", 32'h0000_1000, 1'b1, 32'h0000_0800);
    do_upd(32'h0000_1000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    look("hyst 2nd nt", 32'h0000_1000, 1'b0, 32'h0000_1004);
    chk("hyst cnt", {16'd0, mispredict_cnt}, 32'd3);

    // Alias: 0x1040 shares slot 0 with 0x1000.
    do_upd(32'h0000_1040, 1'b1, 32'h0000_2000, 1'b0, 1'b1);
    look("alias old", 32'h0000_1000, 1'b0, 32'h0000_1004);
    look("alias new", 32'h0000_1040, 1'b1, 32'h0000_2000);
    look("alias low bits", 32'h0000_1042, 1'b1, 32'h0000_2000);

    // Taken hit retargets; not-taken miss does not evict.
    do_upd(32'h0000_1040, 1'b1, 32'h0000_2400, 1'b1, 1'b1);
    look("retarget", 32'h0000_1040, 1'b1, 32'h0000_2400);
    do_upd(32'h0000_1100, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    chk("nt miss misp", {31'd0, mispredict}, 32'd1);
    look("nt miss keeps", 32'h0000_1040, 1'b1, 32'h0000_2400);
    look("nt miss no alloc", 32'h0000_1100, 1'b0, 32'h0000_1104);

    // Non-branch update with mismatched prediction is ignored.
    do_upd(32'h0000_1080, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
    chk("nonbr mispredict", {31'd0, mispredict}, 32'd0);
    chk("nonbr cnt", {16'd0, mispredict_cnt}, 32'd5);
    look("nonbr lookup", 32'h0000_1080, 1'b0, 32'h0000_1084);

    // pc + 4 wraps at 2^32.
    look("pc wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Mispredict counter wrap to 0x0000.
    drive_upd(32'h0000_1100, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    repeat (65536 - 5) step();
    upd_valid = 1'b0;
    #1;
    chk("cnt wrap", {16'd0, mispredict_cnt}, 32'd0);
    chk("wrap misp", {31'd0, mispredict}, 32'd1);

    // Asynchronous reset between edges, with an update presented.
    pred_pc = 32'h0000_1040;
    step();
    #2;
    drive_upd(32'h0000_1200, 1'b1, 32'h0000_5000, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst mispredict", {31'd0, mispredict}, 32'd0);
    chk("arst cnt", {16'd0, mispredict_cnt}, 32'd0);
    chk("arst pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("arst pred_target", pred_target, 32'h0000_1044);
    step();
    rst = 1'b0;
    upd_valid = 1'b0;
    look("arst discard", 32'h0000_1200, 1'b0, 32'h0000_1204);
    step();
    chk("post-rst cnt", {16'd0, mispredict_cnt}, 32'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter: ENTRIES, 16, number of table entries (power of two, 2..256); IDX_W = log2(ENTRIES).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: pred_pc  input  32  fetch-stage PC to predict.
REQ-005 SHALL have port: pred_taken  output  1  predicted direction for pred_pc.
REQ-006 SHALL have port: pred_target  output  32  predicted next PC.
REQ-007 SHALL have port: upd_valid  input  1  execute-stage resolution strobe, one per resolved instruction.
REQ-008 SHALL have port: upd_is_branch  input  1  resolved instruction is a conditional branch.
REQ-009 SHALL have port: upd_pc  input  32  PC of the resolved instruction.
REQ-010 SHALL have port: upd_taken  input  1  actual outcome, the branch_taken result from the execute-stage comparator.
REQ-011 SHALL have port: upd_target  input  32  actual branch target.
REQ-012 SHALL have port: upd_pred_taken  input  1  direction that was predicted for this instruction, carried down the pipeline.
REQ-013 SHALL have port: mispredict  output  1  registered pulse when the resolved direction differs from the predicted direction.
REQ-014 SHALL have port: mispredict_cnt  output  16  count of mispredictions.

Function
REQ-015 SHALL hold per entry: valid (1), tag = pc[31:IDX_W+2], target (32), 2-bit counter (00 SNT, 01 WNT, 10 WT, 11 ST).
REQ-016 SHALL index with pc[IDX_W+1:2]; pc[1:0] ignored.
REQ-017 SHALL define hit as valid and stored tag equal to the pred_pc tag.
REQ-018 SHALL produce the prediction combinationally in the same cycle: pred_taken = hit and counter[1]; pred_target = stored target if pred_taken, else pred_pc + 4 (mod 2^32).
REQ-019 SHALL act on an update only when upd_valid = 1 and upd_is_branch = 1; all other cycles leave the table unchanged.
REQ-020 SHALL, on an update that hits: increment the counter when taken, saturating at 11; decrement it when not taken, saturating at 00; overwrite target with upd_target only when taken.
REQ-021 SHALL, on an update that misses with upd_taken = 1: allocate (replace) the indexed entry with valid = 1, new tag, target = upd_target, counter = 10.
REQ-022 SHALL, on an update that misses with upd_taken = 0: not modify the entry.
REQ-023 SHALL make table writes take effect at the next rising edge; a lookup and update to the same index in the same cycle returns pre-update state.
REQ-024 SHALL assert mispredict for exactly one cycle, in the cycle after a qualifying update, when upd_taken != upd_pred_taken.
REQ-025 SHALL increment mispredict_cnt on every mispredict pulse, wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL NOT raise mispredict or change mispredict_cnt for updates with upd_is_branch = 0.

Reset
REQ-027 SHALL, while rst = 1, clear all valid bits, set all counters to 01, set targets and tags to 0, mispredict = 0 and mispredict_cnt = 0, regardless of clk.
REQ-028 SHALL, with rst asserted mid-operation, discard any update presented in the same cycle; pred_taken = 0 and pred_target = pred_pc + 4 during and after reset until an allocation occurs.

Verification
REQ-029 SHALL cover cold lookup: after reset, pred_pc = 0x0000_1000 -> pred_taken = 0, pred_target = 0x0000_1004.
REQ-030 SHALL cover allocation: update pc 0x1000, taken, target 0x0800, pred_taken 0 -> next cycle mispredict = 1, cnt = 1; lookup 0x1000 -> taken, target 0x0800.
REQ-031 SHALL cover saturation and hysteresis: from counter 10, three taken updates then one not-taken -> counter 10, still predicts taken; a second not-taken -> 01, predicts not taken, target 0x1004.
REQ-032 SHALL cover an alias conflict (ENTRIES = 16): after allocating 0x1000, a taken update at 0x1040 replaces it -> lookup 0x1000 misses, 0x1040 hits.
REQ-033 SHALL cover same-cycle read/write plus non-branch filtering: lookup and allocating update on one index return the old miss that cycle; an update with upd_is_branch = 0 and mismatched prediction -> no table change, no pulse.
REQ-034 SHALL cover counter wrap and async reset: 65536 mispredicts -> cnt = 0x0000; rst asserted between edges -> outputs clear immediately.
